time_set_control: RTL and testbench

Front-panel input controller for the digital clock. It turns the mode/next/inc keys into the mode code, the cursor position (pos) and edited digit values that the display controller consumes. It also commits edits: to the time counter through a one-cycle load strobe, and to the alarm registers it owns. It sits between the key debouncers and the clock counter / display_control.

---
 rtl/time_set_control.sv | 197 +++++++++++++++++++
 tb/tb_time_set_control.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_control.sv
// Purpose : front-panel key controller; mode/next/inc keys drive the mode code, cursor and edit digits,
//           commit the edit buffer to the time counter (time_load) and to the owned alarm registers.
// Latency : one clk from the first high key sample to the output change; backpressure: none (keys are edge events).
// Ports   : clk, rst_n (sync, active low), tick_1hz, btn_mode/btn_next/btn_inc, cur_* (live time) ->
//           mode, pos, set_* (edit buffer), time_load (1-clk strobe), alarm_* (committed alarm time).
module time_set_control #(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic [1:0] cur_hour_tens,
    input  logic [3:0] cur_hour_ones,
    input  logic [2:0] cur_min_tens,
    input  logic [3:0] cur_min_ones,
    input  logic [2:0] cur_sec_tens,
    input  logic [3:0] cur_sec_ones,
    output logic [1:0] mode,
    output logic [2:0] pos,
    output logic [1:0] set_hour_tens,
    output logic [3:0] set_hour_ones,
    output logic [2:0] set_min_tens,
    output logic [3:0] set_min_ones,
    output logic [2:0] set_sec_tens,
    output logic [3:0] set_sec_ones,
    output logic       time_load,
    output logic [1:0] alarm_hour_tens,
    output logic [3:0] alarm_hour_ones,
    output logic [2:0] alarm_minute_tens,
    output logic [3:0] alarm_minute_ones
);

    typedef enum logic [1:0] {
        NORMAL    = 2'b00,
        CLOCK_SET = 2'b01,
        ALARM_SET = 2'b10
    } mode_t;

    localparam logic [5:0] TO_LAST = 6'(TIMEOUT_S - 1);

    mode_t      state, state_d;
    logic [2:0] pos_d;
    logic [1:0] sht_d;
    logic [3:0] sho_d;
    logic [2:0] smt_d;
    logic [3:0] smo_d;
    logic [2:0] sst_d;
    logic [3:0] sso_d;
    logic       time_load_d;
    logic [1:0] aht_d;
    logic [3:0] aho_d;
    logic [2:0] amt_d;
    logic [3:0] amo_d;
    logic [5:0] tcnt, tcnt_d;
    logic       mode_q, next_q, inc_q;
    logic       ev_mode, ev_next, ev_inc;
    logic [3:0] hour_ones_max;

    // Rising-edge events with fixed priority mode > next > inc; losers are dropped.
    assign ev_mode = btn_mode & ~mode_q;
    assign ev_next = btn_next & ~next_q & ~ev_mode;
    assign ev_inc  = btn_inc  & ~inc_q  & ~ev_mode & ~(btn_next & ~next_q);

    assign hour_ones_max = (set_hour_tens == 2'd2) ? 4'd3 : 4'd9;
    assign mode          = state;

    always_comb begin
        state_d     = state;
        pos_d       = pos;
        sht_d       = set_hour_tens;
        sho_d       = set_hour_ones;
        smt_d       = set_min_tens;
        smo_d       = set_min_ones;
        sst_d       = set_sec_tens;
        sso_d       = set_sec_ones;
        time_load_d = 1'b0;
        aht_d       = alarm_hour_tens;
        aho_d       = alarm_hour_ones;
        amt_d       = alarm_minute_tens;
        amo_d       = alarm_minute_ones;
        tcnt_d      = tcnt;

        // Edge after the commit strobe: preload the edit buffer with the alarm time.
        if (time_load) begin
            sht_d = alarm_hour_tens;
            sho_d = alarm_hour_ones;
            smt_d = alarm_minute_tens;
            smo_d = alarm_minute_ones;
            sst_d = 3'd0;
            sso_d = 4'd0;
        end

        if (state == NORMAL) begin
            tcnt_d = 6'd0;
            if (ev_mode) begin
                state_d = CLOCK_SET;
                pos_d   = 3'd1;
                sht_d   = cur_hour_tens;
                sho_d   = cur_hour_ones;
                smt_d   = cur_min_tens;
                smo_d   = cur_min_ones;
                sst_d   = cur_sec_tens;
                sso_d   = cur_sec_ones;
            end
        end else if (!time_load && ev_mode) begin
            tcnt_d = 6'd0;
            pos_d  = 3'd1;
            if (state == CLOCK_SET) begin
                state_d     = ALARM_SET;
                time_load_d = 1'b1;
            end else begin
                state_d = NORMAL;
                pos_d   = 3'd0;
                aht_d   = set_hour_tens;
                aho_d   = set_hour_ones;
                amt_d   = set_min_tens;
                amo_d   = set_min_ones;
            end
        end else if (!time_load && ev_next) begin
            tcnt_d = 6'd0;
            if (state == CLOCK_SET) begin
                pos_d = (pos >= 3'd6) ? 3'd1 : pos + 3'd1;
            end else begin
                pos_d = (pos >= 3'd4) ? 3'd1 : pos + 3'd1;
            end
        end else if (!time_load && ev_inc) begin
            tcnt_d = 6'd0;
            case (pos)
                3'd1: begin
                    sht_d = (set_hour_tens >= 2'd2) ? 2'd0 : set_hour_tens + 2'd1;
                    // Never present hours 24..29.
                    if (sht_d == 2'd2 && set_hour_ones > 4'd3) sho_d = 4'd3;
                end
                3'd2: sho_d = (set_hour_ones >= hour_ones_max) ? 4'd0 : set_hour_ones + 4'd1;
                3'd3: smt_d = (set_min_tens >= 3'd5) ? 3'd0 : set_min_tens + 3'd1;
                3'd4: smo_d = (set_min_ones >= 4'd9) ? 4'd0 : set_min_ones + 4'd1;
                3'd5: sst_d = (set_sec_tens >= 3'd5) ? 3'd0 : set_sec_tens + 3'd1;
                3'd6: sso_d = (set_sec_ones >= 4'd9) ? 4'd0 : set_sec_ones + 4'd1;
                default: ;
            endcase
        end else if (tick_1hz) begin
            // Idle timeout: leave without committing anything.
            if (tcnt >= TO_LAST) begin
                state_d = NORMAL;
                pos_d   = 3'd0;
                tcnt_d  = 6'd0;
            end else begin
                tcnt_d = tcnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= NORMAL;
            pos               <= 3'd0;
            set_hour_tens     <= 2'd0;
            set_hour_ones     <= 4'd0;
            set_min_tens      <= 3'd0;
            set_min_ones      <= 4'd0;
            set_sec_tens      <= 3'd0;
            set_sec_ones      <= 4'd0;
            time_load         <= 1'b0;
            alarm_hour_tens   <= 2'd0;
            alarm_hour_ones   <= 4'd0;
            alarm_minute_tens <= 3'd0;
            alarm_minute_ones <= 4'd0;
            tcnt              <= 6'd0;
            // Held keys through reset must not look like fresh presses.
            mode_q            <= 1'b1;
            next_q            <= 1'b1;
            inc_q             <= 1'b1;
        end else begin
            state             <= state_d;
            pos               <= pos_d;
            set_hour_tens     <= sht_d;
            set_hour_ones     <= sho_d;
            set_min_tens      <= smt_d;
            set_min_ones      <= smo_d;
            set_sec_tens      <= sst_d;
            set_sec_ones      <= sso_d;
            time_load         <= time_load_d;
            alarm_hour_tens   <= aht_d;
            alarm_hour_ones   <= aho_d;
            alarm_minute_tens <= amt_d;
            alarm_minute_ones <= amo_d;
            tcnt              <= tcnt_d;
            mode_q            <= btn_mode;
            next_q            <= btn_next;
            inc_q             <= btn_inc;
        end
    end

endmodule

// File: tb/tb_time_set_control.sv
module tb_time_set_control;

    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst_n, tick_1hz, btn_mode, btn_next, btn_inc;
    logic [1:0] cur_hour_tens;
    logic [3:0] cur_hour_ones;
    logic [2:0] cur_min_tens;
    logic [3:0] cur_min_ones;
    logic [2:0] cur_sec_tens;
    logic [3:0] cur_sec_ones;
    logic [1:0] mode;
    logic [2:0] pos;
    logic [1:0] set_hour_tens;
    logic [3:0] set_hour_ones;
    logic [2:0] set_min_tens;
    logic [3:0] set_min_ones;
    logic [2:0] set_sec_tens;
    logic [3:0] set_sec_ones;
    logic       time_load;
    logic [1:0] alarm_hour_tens;
    logic [3:0] alarm_hour_ones;
    logic [2:0] alarm_minute_tens;
    logic [3:0] alarm_minute_ones;

    time_set_control #(.TIMEOUT_S(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .cur_hour_tens(cur_hour_tens), .cur_hour_ones(cur_hour_ones),
        .cur_min_tens(cur_min_tens), .cur_min_ones(cur_min_ones),
        .cur_sec_tens(cur_sec_tens), .cur_sec_ones(cur_sec_ones),
        .mode(mode), .pos(pos),
        .set_hour_tens(set_hour_tens), .set_hour_ones(set_hour_ones),
        .set_min_tens(set_min_tens), .set_min_ones(set_min_ones),
        .set_sec_tens(set_sec_tens), .set_sec_ones(set_sec_ones),
        .time_load(time_load),
        .alarm_hour_tens(alarm_hour_tens), .alarm_hour_ones(alarm_hour_ones),
        .alarm_minute_tens(alarm_minute_tens), .alarm_minute_ones(alarm_minute_ones)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the clock as digit arrays plus a handful of scalars.
    int m_mode, m_pos, m_cnt;
    int md[6];   // edit digits: hour tens .. sec ones
    int ma[4];   // alarm digits: hour tens .. minute ones
    bit m_tl, m_pre;
    bit pm, pn, pi;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_dig(input int i);
        case (i)
            0: return int'(set_hour_tens);
            1: return int'(set_hour_ones);
            2: return int'(set_min_tens);
            3: return int'(set_min_ones);
            4: return int'(set_sec_tens);
            default: return int'(set_sec_ones);
        endcase
    endfunction

    function automatic int dut_alm(input int i);
        case (i)
            0: return int'(alarm_hour_tens);
            1: return int'(alarm_hour_ones);
            2: return int'(alarm_minute_tens);
            default: return int'(alarm_minute_ones);
        endcase
    endfunction

    function automatic int cur_dig(input int i);
        case (i)
            0: return int'(cur_hour_tens);
            1: return int'(cur_hour_ones);
            2: return int'(cur_min_tens);
            3: return int'(cur_min_ones);
            4: return int'(cur_sec_tens);
            default: return int'(cur_sec_ones);
        endcase
    endfunction

    function automatic int dig_max(input int i);
        case (i)
            0: return 2;
            1: return (md[0] == 2) ? 3 : 9;
            2, 4: return 5;
            default: return 9;
        endcase
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        bit em, en, ei, any;
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_cnt = 0; m_tl = 0; m_pre = 0;
            foreach (md[i]) md[i] = 0;
            foreach (ma[i]) ma[i] = 0;
            pm = 1; pn = 1; pi = 1;
            return;
        end
        em  = btn_mode && !pm;
        en  = btn_next && !pn;
        ei  = btn_inc  && !pi;
        any = em || en || ei;
        pm = btn_mode; pn = btn_next; pi = btn_inc;
        m_pre = m_tl;
        m_tl  = 0;
        if (m_pre) begin
            for (int i = 0; i < 4; i++) md[i] = ma[i];
            md[4] = 0; md[5] = 0;
        end
        if (m_mode == 0) begin
            m_cnt = 0;
            if (em) begin
                m_mode = 1; m_pos = 1;
                for (int i = 0; i < 6; i++) md[i] = cur_dig(i);
            end
        end else if (!m_pre && any) begin
            m_cnt = 0;
            if (em) begin
                if (m_mode == 1) begin
                    m_mode = 2; m_tl = 1; m_pos = 1;
                end else begin
                    m_mode = 0; m_pos = 0;
                    for (int i = 0; i < 4; i++) ma[i] = md[i];
                end
            end else if (en) begin
                m_pos = (m_pos % ((m_mode == 1) ? 6 : 4)) + 1;
            end else begin
                int k;
                k = m_pos - 1;
                md[k] = (md[k] >= dig_max(k)) ? 0 : md[k] + 1;
                if (k == 0 && md[0] == 2 && md[1] > 3) md[1] = 3;
            end
        end else if (tick_1hz) begin
            m_cnt++;
            if (m_cnt >= TO) begin
                m_mode = 0; m_pos = 0; m_cnt = 0;
            end
        end
    endtask

    // One clock: update the model, let the edge pass, compare every output.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("mode", int'(mode), m_mode);
        chk("pos", int'(pos), m_pos);
        chk("time_load", int'(time_load), int'(m_tl));
        for (int i = 0; i < 6; i++) chk($sformatf("set_dig%0d", i), dut_dig(i), md[i]);
        for (int i = 0; i < 4; i++) chk($sformatf("alarm_dig%0d", i), dut_alm(i), ma[i]);
    endtask

    task automatic press_mode();
        btn_mode = 1; step(); btn_mode = 0; step();
    endtask
    task automatic press_next();
        btn_next = 1; step(); btn_next = 0; step();
    endtask
    task automatic press_inc();
        btn_inc = 1; step(); btn_inc = 0; step();
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour_tens = 2'(h / 10); cur_hour_ones = 4'(h % 10);
        cur_min_tens  = 3'(m / 10); cur_min_ones  = 4'(m % 10);
        cur_sec_tens  = 3'(s / 10); cur_sec_ones  = 4'(s % 10);
    endtask

    initial begin
        int exp_pos[6];
        exp_pos = '{2, 3, 4, 5, 6, 1};
        rst_n = 0; tick_1hz = 0; btn_mode = 1; btn_next = 0; btn_inc = 0;
        set_cur(19, 47, 5);
        #2;
        // Mode key held through reset: no event on release.
        repeat (3) step();
        chk("reset_mode", int'(mode), 0);
        rst_n = 1;
        repeat (3) step();
        chk("held_mode", int'(mode), 0);
        chk("held_tl", int'(time_load), 0);
        btn_mode = 0; step();
        btn_mode = 1; step();
        chk("enter_clkset", int'(mode), 1);
        chk("enter_pos", int'(pos), 1);
        btn_mode = 0; step();

        // Hour tens 1 -> 2 clamps hour ones 9 -> 3.
        press_inc();
        chk("clamp_ht", int'(set_hour_tens), 2);
        chk("clamp_ho", int'(set_hour_ones), 3);
        chk("keep_mt", int'(set_min_tens), 4);
        chk("keep_so", int'(set_sec_ones), 5);

        for (int i = 0; i < 6; i++) begin
            press_next();
            chk("next_clk", int'(pos), exp_pos[i]);
        end
        repeat (4) press_next();
        repeat (5) press_inc();
        chk("st_five", int'(set_sec_tens), 5);
        press_inc();
        chk("st_wrap", int'(set_sec_tens), 0);
        press_next();
        repeat (4) press_inc();
        chk("so_nine", int'(set_sec_ones), 9);
        press_inc();
        chk("so_wrap", int'(set_sec_ones), 0);

        // Commit to the time counter: one-cycle strobe carrying 23:47:00.
        btn_mode = 1; step();
        chk("tl_pulse", int'(time_load), 1);
        chk("tl_ht", int'(set_hour_tens), 2);
        chk("tl_ho", int'(set_hour_ones), 3);
        chk("tl_mo", int'(set_min_ones), 7);
        btn_mode = 0; step();
        chk("tl_drop", int'(time_load), 0);
        chk("alm_mode", int'(mode), 2);
        chk("alm_pos", int'(pos), 1);
        chk("alm_preload", int'(set_hour_ones), 0);

        for (int i = 0; i < 4; i++) begin
            press_next();
            chk("next_alm", int'(pos), (i == 3) ? 1 : i + 2);
        end
        press_next(); repeat (6) press_inc();
        press_next(); repeat (3) press_inc();
        press_mode();
        chk("alm_ho", int'(alarm_hour_ones), 6);
        chk("alm_mt", int'(alarm_minute_tens), 3);
        chk("alm_exit_mode", int'(mode), 0);
        chk("alm_exit_pos", int'(pos), 0);
        press_mode(); press_mode();
        chk("reload_ho", int'(set_hour_ones), 6);
        chk("reload_mt", int'(set_min_tens), 3);
        press_mode();

        // Timeout with no keys discards the edit.
        press_mode(); press_inc();
        repeat (TO) begin
            tick_1hz = 1; step(); tick_1hz = 0; step();
        end
        chk("timeout_mode", int'(mode), 0);
        chk("timeout_alarm", int'(alarm_hour_ones), 6);

        // All three keys at once: only the mode transition happens.
        set_cur(8, 15, 42);
        press_mode();
        btn_mode = 1; btn_next = 1; btn_inc = 1; step();
        chk("coinc_mode", int'(mode), 2);
        chk("coinc_pos", int'(pos), 1);
        chk("coinc_ho", int'(set_hour_ones), 8);
        btn_mode = 0; btn_next = 0; btn_inc = 0; step();

        // Reset mid-edit.
        press_mode(); press_mode(); press_inc();
        rst_n = 0; step();
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_alarm", int'(alarm_hour_ones), 0);
        rst_n = 1; step();

        // Randomized phase against the model.
        for (int c = 0; c < 3000; c++) begin
            int h;
            h = $urandom_range(0, 23);
            set_cur(h, $urandom_range(0, 59), $urandom_range(0, 59));
            btn_mode = ($urandom_range(0, 9) == 0);
            btn_next = ($urandom_range(0, 2) == 0);
            btn_inc  = ($urandom_range(0, 1) == 0);
            tick_1hz = ($urandom_range(0, 7) == 0);
            rst_n    = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
